esteira_posicionamento: RTL and testbench
=========================================

Name: esteira_posicionamento

Overview:
Conveyor motion controller sitting directly downstream of the bottling process FSM. It consumes the FSM's combinational move command and drives the belt motor. It tracks which station the current bottle is at (ENCHIMENTO -> CQ -> LACRE -> ENCHIMENTO, wrapping) using a per-hop travel timer. It returns the Motor_Parado_Pos_* status flags that the FSM waits on.

Parameters:
T_TRAVEL, 50, clk cycles the motor runs per station hop; legal range 1..2^16-1.
CNT_W, 8, width of the completed-loop counter.

Ports:
clk  input  1  system clock
Reset  input  1  reset, asynchronous, active-high
Comando_Mover_Esteira  input  1  move request from process FSM; may be a 1-cycle pulse or a held level
Sensor_Obstrucao  input  1  belt obstruction; high pauses or inhibits motion
Motor_Ligado  output  1  belt motor enable
Motor_Parado_Pos_Enchimento  output  1  belt stopped at fill station
Motor_Parado_Pos_CQ  output  1  belt stopped at quality-control station
Motor_Parado_Pos_Lacre  output  1  belt stopped at seal station
Posicao  output  2  current station: 00 ENCHIMENTO, 01 CQ, 10 LACRE
Chegada  output  1  1-cycle pulse on arrival at a station
Contador_Voltas  output  CNT_W  number of arrivals at ENCHIMENTO since reset

Behaviour:
- All outputs are registered or decoded from registers only; no combinational path from inputs to outputs.
- States:
  - PARADO_POS: idle at a station.
  - MOVENDO: motor running.
  - PAUSADO: obstruction hold.
- Internal registers: 16-bit timer, 2-bit target, 1-bit pending request.
- Reset (asynchronous, effective immediately, including mid-motion):
  - state PARADO_POS, Posicao=00, timer=0, pending=0.
  - Motor_Ligado=0, Chegada=0, Contador_Voltas=0.
  - Motor_Parado_Pos_Enchimento=1, CQ=0, Lacre=0.
  - No homing motion is performed after reset.
- PARADO_POS:
  - If (Comando_Mover_Esteira or pending) and !Sensor_Obstrucao: next edge -> MOVENDO, timer <= T_TRAVEL-1, target <= next(Posicao), pending <= 0.
  - If Comando_Mover_Esteira and Sensor_Obstrucao: pending <= 1 and stay. A 1-cycle command is therefore never lost.
- next(Posicao) mapping: 00->01, 01->10, 10->00, illegal 11->00.
- MOVENDO:
  - Motor_Ligado=1; all Motor_Parado_Pos_* = 0.
  - If Sensor_Obstrucao: -> PAUSADO, timer frozen.
  - Else if timer==0: -> PARADO_POS, Posicao <= target, Chegada=1 for exactly that first idle cycle.
  - Else timer decrements by 1.
- PAUSADO:
  - Motor_Ligado=0; all Motor_Parado_Pos_* = 0 (belt is between stations).
  - Sensor_Obstrucao low -> MOVENDO next edge, timer resumes from its frozen value.
- Latency:
  - Command sampled high at edge k (idle, no obstruction) -> Motor_Ligado high from k+1 for exactly T_TRAVEL cycles.
  - Arrival (Posicao updated, Parado flag high, Chegada pulse) at edge k+1+T_TRAVEL.
  - Pause cycles add 1:1 to this latency.
- Motor_Parado_Pos_X = (state==PARADO_POS && Posicao==X).
- Comando_Mover_Esteira is ignored in MOVENDO and PAUSADO and does not set pending there.
- A command held high through arrival starts the next hop in the first idle cycle. The Parado flag is therefore high for exactly 1 cycle. This is required so that a rejected bottle travels CQ->LACRE->ENCHIMENTO with no stop.
- Contador_Voltas increments on each arrival with target 00 and wraps modulo 2^CNT_W.
- Simultaneous timer==0 and Sensor_Obstrucao in MOVENDO: the obstruction wins; go to PAUSADO with timer=0. Arrival occurs on the first cycle after resume.

Test Plan:
- Reset then idle, T_TRAVEL=4 -> Posicao=00, Motor_Parado_Pos_Enchimento=1, Motor_Ligado=0, Contador_Voltas=0.
- 1-cycle Comando pulse at edge k -> Motor_Ligado high edges k+1..k+4; Posicao=01, Motor_Parado_Pos_CQ=1 and Chegada=1 at edge k+5.
- Command held high for three hops from 00 -> Posicao sequence 01,10,00; each Parado flag high exactly 1 cycle; Contador_Voltas=1; total 15 cycles.
- Sensor_Obstrucao high for 3 cycles mid-hop -> Motor_Ligado low during the pause, all Parado flags 0, arrival delayed by exactly 3 cycles.
- Comando pulse while idle with Sensor_Obstrucao high -> no motion, pending held; obstruction released -> motion starts next edge.
- Reset asserted mid-hop between edges -> outputs return to reset values immediately without waiting for clk; CNT_W=2 with 5 loops -> Contador_Voltas=1 (wrap).

Source files
------------

// File: rtl/esteira_posicionamento.sv
// Belt motion controller for the bottling line.
// Runs the belt motor one station hop per move request and keeps track of
// which station (ENCHIMENTO -> CQ -> LACRE -> ENCHIMENTO) the bottle is at.
// Every output is a register or a decode of registers.
module esteira_posicionamento #(
    parameter int T_TRAVEL = 50,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Comando_Mover_Esteira,
    input  logic             Sensor_Obstrucao,
    output logic             Motor_Ligado,
    output logic             Motor_Parado_Pos_Enchimento,
    output logic             Motor_Parado_Pos_CQ,
    output logic             Motor_Parado_Pos_Lacre,
    output logic [1:0]       Posicao,
    output logic             Chegada,
    output logic [CNT_W-1:0] Contador_Voltas
);

    typedef enum logic [1:0] {
        PARADO_POS = 2'b00,
        MOVENDO    = 2'b01,
        PAUSADO    = 2'b10
    } estado_t;

    localparam logic [1:0] POS_ENCHIMENTO = 2'b00;
    localparam logic [1:0] POS_CQ         = 2'b01;
    localparam logic [1:0] POS_LACRE      = 2'b10;

    localparam logic [15:0] TIMER_CARGA = 16'(T_TRAVEL - 1);

    estado_t          estado, estado_prox;
    logic [15:0]      timer, timer_prox;
    logic [1:0]       posicao, posicao_prox;
    logic [1:0]       alvo, alvo_prox;
    logic             pendente, pendente_prox;
    logic             chegada, chegada_prox;
    logic [CNT_W-1:0] contador, contador_prox;

    // Station that follows the given one; the unused code 11 recovers to ENCHIMENTO.
    function automatic logic [1:0] proxima_posicao(input logic [1:0] pos);
        case (pos)
            POS_ENCHIMENTO: proxima_posicao = POS_CQ;
            POS_CQ:         proxima_posicao = POS_LACRE;
            default:        proxima_posicao = POS_ENCHIMENTO;
        endcase
    endfunction

    // State register plus all datapath registers; reset takes effect immediately.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            estado   <= PARADO_POS;
            timer    <= '0;
            posicao  <= POS_ENCHIMENTO;
            alvo     <= POS_ENCHIMENTO;
            pendente <= 1'b0;
            chegada  <= 1'b0;
            contador <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values
            // computed by the next-state logic, independent of statement order.
            estado   <= estado_prox;
            timer    <= timer_prox;
            posicao  <= posicao_prox;
            alvo     <= alvo_prox;
            pendente <= pendente_prox;
            chegada  <= chegada_prox;
            contador <= contador_prox;
        end
    end

    // Next-state and datapath update logic for the three motion states.
    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path through
        // the case leaves it unassigned, which would infer a latch.
        estado_prox   = estado;
        timer_prox    = timer;
        posicao_prox  = posicao;
        alvo_prox     = alvo;
        pendente_prox = pendente;
        chegada_prox  = 1'b0;
        contador_prox = contador;

        case (estado)
            PARADO_POS: begin
                if ((Comando_Mover_Esteira || pendente) && !Sensor_Obstrucao) begin
                    estado_prox   = MOVENDO;
                    timer_prox    = TIMER_CARGA;
                    alvo_prox     = proxima_posicao(posicao);
                    pendente_prox = 1'b0;
                end else if (Comando_Mover_Esteira && Sensor_Obstrucao) begin
                    // Remember a short command that arrived while blocked.
                    pendente_prox = 1'b1;
                end
            end

            MOVENDO: begin
                if (Sensor_Obstrucao) begin
                    // Obstruction wins even when the hop would finish this edge.
                    estado_prox = PAUSADO;
                end else if (timer == 16'd0) begin
                    estado_prox  = PARADO_POS;
                    posicao_prox = alvo;
                    chegada_prox = 1'b1;
                    if (alvo == POS_ENCHIMENTO)
                        contador_prox = contador + CNT_W'(1);
                end else begin
                    timer_prox = timer - 16'd1;
                end
            end

            PAUSADO: begin
                if (!Sensor_Obstrucao) begin
                    estado_prox = MOVENDO;
                    // The resume edge takes the count the interrupted cycle
                    // skipped, so each paused cycle delays arrival by one.
                    if (timer != 16'd0)
                        timer_prox = timer - 16'd1;
                end
            end

            default: begin
                estado_prox = PARADO_POS;
            end
        endcase
    end

    // Output decode from registered state only.
    assign Motor_Ligado                = (estado == MOVENDO);
    assign Motor_Parado_Pos_Enchimento = (estado == PARADO_POS) && (posicao == POS_ENCHIMENTO);
    assign Motor_Parado_Pos_CQ         = (estado == PARADO_POS) && (posicao == POS_CQ);
    assign Motor_Parado_Pos_Lacre      = (estado == PARADO_POS) && (posicao == POS_LACRE);
    assign Posicao                     = posicao;
    assign Chegada                     = chegada;
    assign Contador_Voltas             = contador;

endmodule

// File: tb/tb_esteira_posicionamento.sv
// Self-checking bench for esteira_posicionamento (T_TRAVEL=4, CNT_W=2).
// Each commanded hop pushes its expected arrival (cycle, station, loop count)
// to a scoreboard; a monitor pops and compares on every Chegada pulse.
module tb_esteira_posicionamento;

    localparam int T_TRAVEL = 4;
    localparam int CNT_W    = 2;

    logic             clk;
    logic             Reset;
    logic             Comando_Mover_Esteira;
    logic             Sensor_Obstrucao;
    logic             Motor_Ligado;
    logic             Motor_Parado_Pos_Enchimento;
    logic             Motor_Parado_Pos_CQ;
    logic             Motor_Parado_Pos_Lacre;
    logic [1:0]       Posicao;
    logic             Chegada;
    logic [CNT_W-1:0] Contador_Voltas;

    typedef struct {
        int         due;
        logic [1:0] pos;
        logic [1:0] cnt;
    } chegada_t;

    chegada_t   sb[$];
    int         cyc;
    int         n_checks;
    int         n_pass;
    logic [1:0] exp_pos;
    logic [1:0] exp_cnt;

    esteira_posicionamento #(
        .T_TRAVEL(T_TRAVEL),
        .CNT_W   (CNT_W)
    ) dut (
        .clk                        (clk),
        .Reset                      (Reset),
        .Comando_Mover_Esteira      (Comando_Mover_Esteira),
        .Sensor_Obstrucao           (Sensor_Obstrucao),
        .Motor_Ligado               (Motor_Ligado),
        .Motor_Parado_Pos_Enchimento(Motor_Parado_Pos_Enchimento),
        .Motor_Parado_Pos_CQ        (Motor_Parado_Pos_CQ),
        .Motor_Parado_Pos_Lacre     (Motor_Parado_Pos_Lacre),
        .Posicao                    (Posicao),
        .Chegada                    (Chegada),
        .Contador_Voltas            (Contador_Voltas)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Queue one expected arrival for a hop whose arrival edge is 'due'.
    task automatic expect_hop(input int due);
        chegada_t c;
        exp_pos = nxt(exp_pos);
        if (exp_pos == 2'b00) exp_cnt = exp_cnt + 2'd1;
        c.due = due;
        c.pos = exp_pos;
        c.cnt = exp_cnt;
        sb.push_back(c);
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, Motor_Parado_Pos_Lacre, Motor_Parado_Pos_CQ, Motor_Parado_Pos_Enchimento};
    endfunction

    function automatic logic [31:0] flag_of(input logic [1:0] p);
        case (p)
            2'b00:   return 32'b001;
            2'b01:   return 32'b010;
            default: return 32'b100;
        endcase
    endfunction

    // Scoreboard monitor: compare every arrival, flag overdue ones.
    always @(posedge clk) begin
        #1;
        if (!Reset) begin
            if (Chegada) begin
                if (sb.size() == 0) begin
                    check("unexpected_arrival", 32'd1, 32'd0);
                end else begin
                    chegada_t c;
                    c = sb.pop_front();
                    check("arrival_cycle", cyc, c.due);
                    check("arrival_pos", {30'd0, Posicao}, {30'd0, c.pos});
                    check("arrival_cnt", {30'd0, Contador_Voltas}, {30'd0, c.cnt});
                    check("arrival_flag", flags(), flag_of(c.pos));
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                check("arrival_missing", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int c0;
        int n_motor;
        int n_parado;
        cyc = 0;
        n_checks = 0;
        n_pass = 0;
        exp_pos = 2'b00;
        exp_cnt = 2'b00;
        Reset = 1'b1;
        Comando_Mover_Esteira = 1'b0;
        Sensor_Obstrucao = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // Reset / idle state
        check("rst_pos", {30'd0, Posicao}, 32'd0);
        check("rst_flags", flags(), 32'b001);
        check("rst_motor", {31'd0, Motor_Ligado}, 32'd0);
        check("rst_cnt", {30'd0, Contador_Voltas}, 32'd0);
        check("rst_chegada", {31'd0, Chegada}, 32'd0);

        // Single-cycle pulse: 00 -> 01
        Comando_Mover_Esteira = 1'b1;
        expect_hop(cyc + 1 + T_TRAVEL);
        tick();
        Comando_Mover_Esteira = 1'b0;
        for (int i = 0; i < T_TRAVEL; i++) begin
            check("pulse_motor_on", {31'd0, Motor_Ligado}, 32'd1);
            check("pulse_flags_off", flags(), 32'd0);
            tick();
        end
        check("pulse_motor_off", {31'd0, Motor_Ligado}, 32'd0);
        check("pulse_at_cq", flags(), 32'b010);
        tick();
        check("pulse_chegada_1cyc", {31'd0, Chegada}, 32'd0);
        check("pulse_stays_cq", flags(), 32'b010);

        // Held command: three hops 01 -> 10 -> 00 -> 01 without stopping
        c0 = cyc;
        Comando_Mover_Esteira = 1'b1;
        for (int h = 1; h <= 3; h++) expect_hop(c0 + h * (T_TRAVEL + 1));
        n_motor = 0;
        n_parado = 0;
        for (int i = 0; i < 3 * (T_TRAVEL + 1); i++) begin
            tick();
            if (Motor_Ligado) n_motor++;
            if (flags() != 0) n_parado++;
        end
        Comando_Mover_Esteira = 1'b0;
        check("held_motor_cycles", n_motor, 3 * T_TRAVEL);
        check("held_parado_cycles", n_parado, 3);
        tick();
        check("held_idle_cq", flags(), 32'b010);
        check("held_cnt", {30'd0, Contador_Voltas}, 32'd1);

        // Obstruction for 3 cycles mid-hop: 01 -> 10 arrives 3 cycles late
        c0 = cyc;
        Comando_Mover_Esteira = 1'b1;
        expect_hop(c0 + 1 + T_TRAVEL + 3);
        tick();
        Comando_Mover_Esteira = 1'b0;
        tick();
        Sensor_Obstrucao = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_motor_off", {31'd0, Motor_Ligado}, 32'd0);
            check("pause_flags_off", flags(), 32'd0);
        end
        Sensor_Obstrucao = 1'b0;
        tick();
        check("pause_resume_motor", {31'd0, Motor_Ligado}, 32'd1);
        repeat (2) tick();
        check("pause_at_lacre", flags(), 32'b100);

        // Pulse while obstructed: held pending, starts when released
        Comando_Mover_Esteira = 1'b1;
        Sensor_Obstrucao = 1'b1;
        tick();
        Comando_Mover_Esteira = 1'b0;
        repeat (2) begin
            tick();
            check("pend_no_motion", {31'd0, Motor_Ligado}, 32'd0);
            check("pend_at_lacre", flags(), 32'b100);
        end
        Sensor_Obstrucao = 1'b0;
        expect_hop(cyc + 1 + T_TRAVEL);
        tick();
        check("pend_start", {31'd0, Motor_Ligado}, 32'd1);
        repeat (T_TRAVEL) tick();
        check("pend_at_ench", flags(), 32'b001);

        // Three more loops (9 hops) to wrap the 2-bit loop counter 2 -> 1
        c0 = cyc;
        Comando_Mover_Esteira = 1'b1;
        for (int h = 1; h <= 9; h++) expect_hop(c0 + h * (T_TRAVEL + 1));
        repeat (9 * (T_TRAVEL + 1)) tick();
        Comando_Mover_Esteira = 1'b0;
        tick();
        check("wrap_cnt", {30'd0, Contador_Voltas}, 32'd1);
        check("wrap_pos", {30'd0, Posicao}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        // Asynchronous reset mid-hop, between clock edges
        Comando_Mover_Esteira = 1'b1;
        tick();
        Comando_Mover_Esteira = 1'b0;
        tick();
        check("async_pre_moving", {31'd0, Motor_Ligado}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_motor", {31'd0, Motor_Ligado}, 32'd0);
        check("async_pos", {30'd0, Posicao}, 32'd0);
        check("async_flags", flags(), 32'b001);
        check("async_cnt", {30'd0, Contador_Voltas}, 32'd0);
        tick();
        Reset = 1'b0;
        exp_pos = 2'b00;
        exp_cnt = 2'b00;
        repeat (T_TRAVEL + 2) tick();
        check("post_rst_idle", flags(), 32'b001);
        check("post_rst_motor", {31'd0, Motor_Ligado}, 32'd0);
        check("sb_empty_end", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
